// File: rtl/iic_slave_regfile.sv
// iic_slave_regfile
//   Byte-addressed register bank fed by the I2C slave's write-byte stream and
//   read requests. The start byte of a write transaction loads the register
//   pointer. Later data bytes write the register it selects. Reads return the
//   selected register, or 8'hFF when the pointer is outside the bank.
//   Fabric logic sees every register in parallel and can write through a
//   host port.
//
//   Build option: IIC_REGFILE_AUTO_INC_EN
//     defined   - the pointer advances after every data write and every read
//     undefined - the pointer changes only on a start byte
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   fifo_wen           write strobe from the slave
//   fifo_wdata         written byte
//   fifo_wdata_start   marks the pointer (start) byte
//   fifo_ren           read request from the slave
//   fifo_rdata         read byte; holds its value until the next read
//   host_wen           fabric write strobe
//   host_addr          fabric write address
//   host_wdata         fabric write data
//   reg_out            register i on bits [8i+7:8i]
//   reg_wr_strobe      one-cycle pulse on each in-range I2C register write
//   reg_wr_addr        address of that I2C write
module iic_slave_regfile #(
   parameter int REG_COUNT  = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fifo_wen,
   input  logic [7:0]               fifo_wdata,
   input  logic                     fifo_wdata_start,
   input  logic                     fifo_ren,
   output logic [7:0]               fifo_rdata,
   input  logic                     host_wen,
   input  logic [ADDR_WIDTH-1:0]    host_addr,
   input  logic [7:0]               host_wdata,
   output logic [8*REG_COUNT-1:0]   reg_out,
   output logic                     reg_wr_strobe,
   output logic [ADDR_WIDTH-1:0]    reg_wr_addr
);

   // REG_COUNT may equal 2^ADDR_WIDTH, so the range compare needs one extra bit
   localparam int                    AW1     = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0]   COUNT_W = AW1'(REG_COUNT);

   logic [ADDR_WIDTH-1:0] ptr;
   logic                  in_range;
   logic                  start_wr;
   logic                  data_wr;
   logic                  reg_wr;
   logic                  rd;
   logic [7:0]            rd_sel;
   logic [7:0]            regs [REG_COUNT];

   assign in_range = {1'b0, ptr} < COUNT_W;
   assign start_wr = fifo_wen & fifo_wdata_start;
   assign data_wr  = fifo_wen & ~fifo_wdata_start;
   assign reg_wr   = data_wr & in_range;
   // a read that collides with a write is dropped
   assign rd       = fifo_ren & ~fifo_wen;

   // read mux; no match means the pointer is past the bank, which reads as FF
   always_comb begin
      rd_sel = 8'hFF;
      for (int i = 0; i < REG_COUNT; i++)
         if (ptr == ADDR_WIDTH'(i)) rd_sel = regs[i];
   end

`ifdef IIC_REGFILE_AUTO_INC_EN
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_COUNT - 1);
   logic [ADDR_WIDTH-1:0] ptr_adv;

   // wrap at the last implemented register; an out-of-range pointer walks
   // up to the top of the address space and wraps there
   assign ptr_adv = (ptr == LAST) ? '0 : ptr + ADDR_WIDTH'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (start_wr)
         ptr <= fifo_wdata[ADDR_WIDTH-1:0];
`ifdef IIC_REGFILE_AUTO_INC_EN
      else if (data_wr || rd)
         ptr <= ptr_adv;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_rdata    <= 8'h00;
         reg_wr_strobe <= 1'b0;
         reg_wr_addr   <= '0;
      end else begin
         reg_wr_strobe <= reg_wr;
         if (reg_wr) reg_wr_addr <= ptr;
         if (rd)     fifo_rdata  <= rd_sel;
      end
   end

   // one storage byte per register; I2C beats the host on an address clash
   for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);
      logic i2c_hit;
      logic host_hit;

      assign i2c_hit  = reg_wr & (ptr == IDX);
      assign host_hit = host_wen & (host_addr == IDX);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)        regs[i] <= 8'h00;
         else if (i2c_hit)  regs[i] <= fifo_wdata;
         else if (host_hit) regs[i] <= host_wdata;
      end

      assign reg_out[8*i +: 8] = regs[i];
   end

endmodule

// File: tb/tb_iic_slave_regfile.sv
// Bench for iic_slave_regfile: two instances (16 and 12 registers) share one
// directed stimulus stream. A behavioural model predicts every output and is
// compared each cycle; literal checks pin the model to hand-worked values.
module tb_iic_slave_regfile;

`ifdef IIC_REGFILE_AUTO_INC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_wen = 1'b0;
   logic [7:0]  fifo_wdata = 8'h00;
   logic        fifo_wdata_start = 1'b0;
   logic        fifo_ren = 1'b0;
   logic        host_wen = 1'b0;
   logic [3:0]  host_addr = 4'h0;
   logic [7:0]  host_wdata = 8'h00;

   logic [7:0]   rd16, rd12;
   logic [127:0] ro16;
   logic [95:0]  ro12;
   logic         st16, st12;
   logic [3:0]   wa16, wa12;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   iic_slave_regfile #(.REG_COUNT(16), .ADDR_WIDTH(4)) u16 (
      .clk(clk), .rst_n(rst_n),
      .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wdata_start(fifo_wdata_start),
      .fifo_ren(fifo_ren), .fifo_rdata(rd16),
      .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
      .reg_out(ro16), .reg_wr_strobe(st16), .reg_wr_addr(wa16));

   iic_slave_regfile #(.REG_COUNT(12), .ADDR_WIDTH(4)) u12 (
      .clk(clk), .rst_n(rst_n),
      .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wdata_start(fifo_wdata_start),
      .fifo_ren(fifo_ren), .fifo_rdata(rd12),
      .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
      .reg_out(ro12), .reg_wr_strobe(st12), .reg_wr_addr(wa12));

   // ---------------- behavioural model ----------------
   logic [7:0] mr  [2][16];
   int         mp  [2];
   logic [7:0] mrd [2];
   logic       ms  [2];
   int         ma  [2];

   function automatic int rc(input int k);
      return (k == 0) ? 16 : 12;
   endfunction

   function automatic int adv(input int k, input int p);
      return (p == rc(k) - 1) ? 0 : (p + 1) % 16;
   endfunction

   function automatic logic [127:0] exp_vec(input int k);
      logic [127:0] v = '0;
      for (int i = 0; i < rc(k); i++) v[8*i +: 8] = mr[k][i];
      return v;
   endfunction

   function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
      return v[8*i +: 8];
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               for (int i = 0; i < 16; i++) mr[k][i] = 8'h00;
               mp[k] = 0; mrd[k] = 8'h00; ms[k] = 1'b0; ma[k] = 0;
            end else begin
               ms[k] = 1'b0;
               if (fifo_wen) begin
                  if (fifo_wdata_start) mp[k] = int'(fifo_wdata) % 16;
                  else begin
                     if (mp[k] < rc(k)) begin
                        mr[k][mp[k]] = fifo_wdata; ms[k] = 1'b1; ma[k] = mp[k];
                     end
                     if (AI) mp[k] = adv(k, mp[k]);
                  end
               end else if (fifo_ren) begin
                  mrd[k] = (mp[k] < rc(k)) ? mr[k][mp[k]] : 8'hFF;
                  if (AI) mp[k] = adv(k, mp[k]);
               end
               // host write lands unless I2C wrote the same register this cycle
               if (host_wen && int'(host_addr) < rc(k) && !(ms[k] && ma[k] == int'(host_addr)))
                  mr[k][host_addr] = host_wdata;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("model_regs16", ro16, exp_vec(0));
         chk("model_regs12", {32'h0, ro12}, exp_vec(1));
         chk("model_rdata16", rd16, mrd[0]);
         chk("model_rdata12", rd12, mrd[1]);
         chk("model_strobe16", st16, ms[0]);
         chk("model_strobe12", st12, ms[1]);
         if (ms[0]) chk("model_waddr16", wa16, ma[0]);
         if (ms[1]) chk("model_waddr12", wa12, ma[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic wen, input logic st, input logic [7:0] d, input logic ren,
                       input logic hw, input logic [3:0] ha, input logic [7:0] hd);
      fifo_wen = wen; fifo_wdata_start = st; fifo_wdata = d; fifo_ren = ren;
      host_wen = hw; host_addr = ha; host_wdata = hd;
      @(negedge clk);
      fifo_wen = 1'b0; fifo_wdata_start = 1'b0; fifo_wdata = 8'h00; fifo_ren = 1'b0;
      host_wen = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
   endtask

   task automatic start_b(input logic [7:0] b); step(1, 1, b, 0, 0, 4'h0, 8'h00); endtask
   task automatic wr_b(input logic [7:0] d);    step(1, 0, d, 0, 0, 4'h0, 8'h00); endtask
   task automatic rd_b();                       step(0, 0, 8'h00, 1, 0, 4'h0, 8'h00); endtask
   task automatic idle();                       step(0, 0, 8'h00, 0, 0, 4'h0, 8'h00); endtask
   task automatic host_b(input logic [3:0] a, input logic [7:0] d); step(0, 0, 8'h00, 0, 1, a, d); endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("reset_regs16", ro16, 128'h0);
      chk("reset_regs12", {32'h0, ro12}, 128'h0);
      chk("reset_rdata16", rd16, 8'h00);
      chk("reset_strobe16", st16, 1'b0);
      chk("reset_waddr16", wa16, 4'h0);
      #1 rst_n = 1'b1;
      cmp_en = 1'b1;

      // back-to-back data bytes after a start byte
      start_b(8'h02);
      wr_b(8'hA5);
      chk("t1_strobe_a", st16, 1'b1);
      chk("t1_waddr_a", wa16, 4'h2);
      wr_b(8'h5A);
      chk("t1_strobe_b", st16, 1'b1);
      chk("t1_waddr_b", wa16, AI ? 4'h3 : 4'h2);
      idle();
      chk("t1_strobe_pulse", st16, 1'b0);
      chk("t1_reg2", byte_of(ro16, 2), AI ? 8'hA5 : 8'h5A);
      chk("t1_reg3", byte_of(ro16, 3), AI ? 8'h5A : 8'h00);

      // pointer wrap at the last register
      start_b(8'h0F);
      wr_b(8'h11);
      wr_b(8'h22);
      chk("t2_reg15", byte_of(ro16, 15), AI ? 8'h11 : 8'h22);
      chk("t2_reg0", byte_of(ro16, 0), AI ? 8'h22 : 8'h00);

      // out-of-range pointer on the 12-register bank
      start_b(8'h0E);
      wr_b(8'h77);
      chk("t3_nostrobe12", st12, 1'b0);
      rd_b();
      chk("t3_rdata_ff", rd12, 8'hFF);
      rd_b();
      chk("t3_rdata_wrap", rd12, AI ? 8'h22 : 8'hFF);

      // host write then I2C read of the same register
      host_b(4'h4, 8'h33);
      start_b(8'h04);
      rd_b();
      chk("t4_rdata16", rd16, 8'h33);
      chk("t4_rdata12", rd12, 8'h33);

      // write and read in the same cycle: the read is dropped
      start_b(8'h06);
      step(1, 0, 8'h44, 1, 0, 4'h0, 8'h00);
      chk("t5_rdata_hold", rd16, 8'h33);
      rd_b();
      chk("t5_rdata_next", rd16, AI ? 8'h00 : 8'h44);

      // I2C and host collisions
      start_b(8'h01);
      step(1, 0, 8'hAA, 0, 1, 4'h1, 8'hBB);
      start_b(8'h03);
      step(1, 0, 8'hCC, 0, 1, 4'h5, 8'hDD);
      idle();
      chk("t6_reg1_i2c_wins", byte_of(ro16, 1), 8'hAA);
      chk("t6_reg3", byte_of(ro16, 3), 8'hCC);
      chk("t6_reg5_host", byte_of(ro16, 5), 8'hDD);

      // host write beyond the 12-register bank
      host_b(4'hD, 8'h9E);
      idle();
      chk("t7_host13_16", byte_of(ro16, 13), 8'h9E);

      // asynchronous reset between edges
      start_b(8'h08);
      wr_b(8'h3C);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_areset_regs16", ro16, 128'h0);
      chk("t8_areset_regs12", {32'h0, ro12}, 128'h0);
      chk("t8_areset_rdata", rd16, 8'h00);
      chk("t8_areset_strobe", st16, 1'b0);
      chk("t8_areset_waddr", wa16, 4'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // first strobe after release is honoured
      start_b(8'h02);
      wr_b(8'h5A);
      chk("t9_strobe", st16, 1'b1);
      chk("t9_waddr", wa16, 4'h2);
      chk("t9_reg2", byte_of(ro16, 2), 8'h5A);
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
